r2r_dac_feeder: RTL
===================

Name: r2r_dac_feeder

Overview:
Digital stage directly upstream of the R2R ladder DAC tile. It produces the 8-bit code that drives the ladder at a programmable sample rate. The code comes from either a streamed sample FIFO or an internal ramp/triangle generator. The code is registered, glitch-free and held between samples, with an update strobe for the external latch/scope trigger.

Parameters:
DATA_W, 8, DAC code width
DEPTH, 8, sample FIFO depth; power of 2, >=2
DIV_W, 16, sample-rate divider width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  1 = run sample timer; 0 = freeze
mode  in  2  00 stream, 01 ramp, 10 triangle, 11 hold
div  in  DIV_W  sample period = div+1 clk cycles
step  in  DATA_W  ramp/triangle increment
in_valid  in  1  sample push request
in_data  in  DATA_W  sample to push
in_ready  out  1  FIFO not full
clr_underrun  in  1  clears underrun flag
dac_code  out  DATA_W  code to R2R ladder, registered
dac_update  out  1  one-cycle pulse when a sample tick is applied
underrun  out  1  sticky: stream tick found FIFO empty
fill  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values: dac_code=0, dac_update=0, underrun=0, fill=0, in_ready=1. Also divider count=0, triangle dir=up.
- Divider: count increments each cycle while enable=1. Tick when count==div, then count<=0.
  - div=0 gives a tick every cycle.
  - A change to div takes effect on the next compare. If count>div, the count wraps through its full range.
- enable=0: count<=0, no ticks, dac_code held, FIFO still accepts pushes.
- Each tick registers the new dac_code and pulses dac_update in the same cycle (all modes, including hold).
- Stream mode on a tick:
  - FIFO non-empty: pop the head into dac_code.
  - FIFO empty: hold dac_code and set underrun.
- Ramp mode on a tick: dac_code <= dac_code+step mod 2^DATA_W (wraps).
- Triangle mode on a tick, dir=up:
  - If dac_code > MAX-step: dac_code<=MAX, dir<=down.
  - Otherwise dac_code += step.
- Triangle mode on a tick, dir=down:
  - If dac_code < step: dac_code<=0, dir<=up.
  - Otherwise dac_code -= step.
- Triangle with step=0: code is constant.
- Any mode other than triangle forces dir<=up.
- Hold mode on a tick: dac_code unchanged.
- Mode changes apply at the next tick. The generators start from the current dac_code.
- FIFO push handshake:
  - Push occurs when in_valid && in_ready.
  - in_ready = !full, combinational from occupancy only and independent of a same-cycle pop. When full, there is no push even if a pop occurs that cycle.
  - A sample pushed at edge N is poppable at a tick on edge N+1 or later.
  - Push into an empty FIFO on the same cycle as a stream tick counts as underrun; the sample stays queued.
  - Simultaneous push and pop when 0<fill<DEPTH: fill is unchanged.
  - Pointers wrap modulo DEPTH.
- underrun: set has priority over clr_underrun in the same cycle.
- Reset asserted mid-operation: all state returns to reset values immediately (async) and FIFO contents are discarded.
- Latency: first sample reaches dac_code div+1 cycles after enable rises (count 0..div).

Optional Feature:
- Macro R2R_FEEDER_MIDSCALE_EN.
- Defined: reset value of dac_code is 2^(DATA_W-1) (0x80 for DATA_W=8), and a stream underrun tick loads midscale instead of holding. Both avoid a rail-to-rail step on the analog output.
- Undefined: reset to 0 and hold on underrun, as above.

Decomposition:
- Package r2r_dac_pkg: mode constants MODE_STREAM/RAMP/TRI/HOLD (2-bit localparams) and the direction encoding.
- Sub-module r2r_sample_fifo (DATA_W, DEPTH):
  - Ports: push/pop/data/full/empty/fill, registered storage, async active-high reset.
- Top contains the divider, the mode mux/generators and the underrun flag.

Test Plan:
- Reset then stream, div=3: push 0x11,0x22,0x33, then enable. dac_code is 0x11/0x22/0x33 at cycles 4/8/12 after enable, with a one-cycle dac_update at each. The 4th tick sets underrun and dac_code stays 0x33 (0x80 with MIDSCALE_EN).
- FIFO full: push 9 samples back-to-back with enable=0. in_ready drops after the 8th, fill=8, the 9th is not accepted. Then enable, div=0: the 8 samples appear on 8 consecutive cycles in order.
- Ramp, step=0x40, div=0, from 0: sequence 0x40,0x80,0xC0,0x00,0x40 (wrap).
- Triangle, step=0x60, from 0: 0x60,0xC0,0xFF(dir down),0x9F,0x3F,0x00(dir up),0x60.
- Async reset mid-stream with fill=5, asserted between edges: outputs go to reset values without a clock. After release, fill=0, underrun=0, in_ready=1.
- clr_underrun asserted on the same cycle as an empty-FIFO tick: underrun stays 1. Asserted the next cycle with no tick: underrun goes 0.

Source files
------------

// File: rtl/r2r_dac_pkg.sv
// Shared constants for the R2R ladder DAC feeder: source-mode
// encodings and the triangle-generator direction type.
package r2r_dac_pkg;

  localparam logic [1:0] MODE_STREAM = 2'b00;
  localparam logic [1:0] MODE_RAMP   = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/r2r_sample_fifo.sv
// Registered sample FIFO; full/empty/fill derive only from occupancy,
// so a same-cycle pop never opens room for a push.
module r2r_sample_fifo
  import r2r_dac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              do_push;
  logic              do_pop;

  assign full     = (cnt_q == AW'(0) + (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign fill     = cnt_q;
  assign pop_data = mem_q[rd_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/r2r_dac_feeder.sv
// R2R ladder code feeder: sample-rate divider, stream/ramp/triangle/hold
// source mux. Option macro: R2R_FEEDER_MIDSCALE_EN.
module r2r_dac_feeder
  import r2r_dac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int DIV_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [DIV_W-1:0]         div,
  input  logic [DATA_W-1:0]        step,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic                     clr_underrun,
  output logic [DATA_W-1:0]        dac_code,
  output logic                     dac_update,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam logic [DATA_W-1:0] CODE_MAX = '1;
  localparam logic [DATA_W-1:0] CODE_MID =
    {1'b1, {(DATA_W-1){1'b0}}};
`ifdef R2R_FEEDER_MIDSCALE_EN
  localparam logic [DATA_W-1:0] CODE_RST = CODE_MID;
`else
  localparam logic [DATA_W-1:0] CODE_RST = '0;
`endif

  logic [DIV_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] code_q, code_d;
  logic              upd_q, upd_d;
  logic              urun_q, urun_d;
  dir_e              dir_q, dir_d;

  logic              tick;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              set_urun;

  r2r_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .fill      (fill)
  );

  // count > div simply keeps counting and wraps through zero
  always_comb begin
    tick    = enable && (count_q == div);
    count_d = '0;
    if (enable && !tick) begin
      count_d = count_q + 1'b1;
    end
  end

  always_comb begin
    code_d   = code_q;
    dir_d    = (mode == MODE_TRI) ? dir_q : DIR_UP;
    fifo_pop = 1'b0;
    set_urun = 1'b0;
    if (tick) begin
      unique case (mode)
        MODE_STREAM: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            code_d   = fifo_data;
          end else begin
            set_urun = 1'b1;
`ifdef R2R_FEEDER_MIDSCALE_EN
            code_d   = CODE_MID;
`endif
          end
        end
        MODE_RAMP: begin
          code_d = code_q + step;
        end
        MODE_TRI: begin
          if (dir_q == DIR_UP) begin
            if (code_q > CODE_MAX - step) begin
              code_d = CODE_MAX;
              dir_d  = DIR_DOWN;
            end else begin
              code_d = code_q + step;
            end
          end else begin
            if (code_q < step) begin
              code_d = '0;
              dir_d  = DIR_UP;
            end else begin
              code_d = code_q - step;
            end
          end
        end
        MODE_HOLD: begin
          code_d = code_q;
        end
        default: code_d = code_q;
      endcase
    end
  end

  // a new underrun wins over a same-cycle clear
  always_comb begin
    upd_d  = tick;
    urun_d = urun_q;
    if (set_urun) begin
      urun_d = 1'b1;
    end else if (clr_underrun) begin
      urun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      code_q  <= CODE_RST;
      upd_q   <= 1'b0;
      urun_q  <= 1'b0;
      dir_q   <= DIR_UP;
    end else begin
      count_q <= count_d;
      code_q  <= code_d;
      upd_q   <= upd_d;
      urun_q  <= urun_d;
      dir_q   <= dir_d;
    end
  end

  assign in_ready   = !fifo_full;
  assign dac_code   = code_q;
  assign dac_update = upd_q;
  assign underrun   = urun_q;

endmodule
